// File: rtl/gpio_pattern_pkg.sv
// Shared definitions for the GPIO pattern transmitter: register map, bit indices,
// FIFO entry layout and FSM state encoding.
package gpio_pattern_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_OE     = 2'd3;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_LOOP   = 1;
    localparam int unsigned CTRL_FLUSH  = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned ST_DONE  = 0;
    localparam int unsigned ST_OVF   = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_EMPTY = 3;
    localparam int unsigned ST_FULL  = 4;
    localparam int unsigned ST_LEVEL = 8;

    // Hold field sized for the widest supported count; narrower builds zero-extend.
    localparam int unsigned PAT_CNT_W = 24;

    typedef struct packed {
        logic [PAT_CNT_W-1:0] hold;
        logic [7:0]           pins;
    } pat_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } pat_state_e;

endpackage

// File: rtl/gpio_pattern_fifo.sv
// Synchronous pattern FIFO with flush and two write ports: a priority re-push of the
// entry being popped, followed by a regular push. Pop on empty / push on full are ignored.
module gpio_pattern_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     repush_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_c,
    output logic                     push_ok_c,
    output logic                     empty_c,
    output logic                     full_c,
    output logic [$clog2(DEPTH):0]   level_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned FW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic              w_pop_ok;
    logic              w_repush_ok;
    logic [FW-1:0]     w_free;
    logic [AW-1:0]     w_push_addr;

    assign level_c     = r_wptr - r_rptr;
    assign empty_c     = (level_c == '0);
    assign full_c      = (level_c == PW'(DEPTH));
    assign rdata_c     = r_mem[r_rptr[AW-1:0]];
    assign w_pop_ok    = pop_i & ~empty_c & ~flush_i;

    // A same-cycle pop frees a slot, so push-on-full alongside a pop is accepted.
    assign w_free      = FW'(DEPTH) - FW'(level_c) + FW'(w_pop_ok);
    assign w_repush_ok = repush_i & ~flush_i & (w_free != '0);
    assign push_ok_c   = push_i & ~flush_i & (w_free > FW'(w_repush_ok));
    assign w_push_addr = r_wptr[AW-1:0] + AW'(w_repush_ok);

    always_ff @(posedge clk_i) begin
        if (w_repush_ok) begin
            r_mem[r_wptr[AW-1:0]] <= rdata_c;
        end
        if (push_ok_c) begin
            r_mem[w_push_addr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= r_wptr + PW'(w_repush_ok) + PW'(push_ok_c);
            r_rptr <= r_rptr + PW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/gpio_pattern_tx.sv
// GPIO pattern transmitter: replays {pins, hold} FIFO entries on the GPIO outputs.
// Optional build macro GPIO_PATTERN_LOOP_EN adds CTRL.loop (popped entries re-pushed).
module gpio_pattern_tx
    import gpio_pattern_pkg::*;
#(
    parameter int unsigned GPIO_NUM   = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [GPIO_NUM-1:0] gpio_oe_o,
    output logic [GPIO_NUM-1:0] gpio_data_o,
    output logic                irq_o,
    input  logic                reg_we_i,
    input  logic                reg_re_i,
    input  logic [31:0]         reg_wdata_i,
    input  logic [3:0]          reg_be_i,
    input  logic [31:0]         reg_addr_i,
    output logic [31:0]         reg_rdata_o
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    pat_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [GPIO_NUM-1:0] r_data, w_data_nxt;
    logic [GPIO_NUM-1:0] r_oe;
    logic                r_enable, r_irq_en, r_done, r_ovf;
    logic                w_pop, w_done_set, w_loop, w_repush;
    logic [1:0]          w_sel;
    logic                w_wr_b0, w_wr_ctrl, w_flush, w_w1c, w_sw_push, w_push_ok;
    pat_entry_t          w_push_entry, w_head;
    logic [CNT_W-1:0]    w_hold;
    logic                w_empty, w_full;
    logic [LVL_W-1:0]    w_level;
    logic                w_unused;

    assign w_sel     = reg_addr_i[3:2];
    assign w_wr_b0   = reg_we_i & reg_be_i[0];
    assign w_wr_ctrl = w_wr_b0 & (w_sel == REG_CTRL);
    assign w_flush   = w_wr_ctrl & reg_wdata_i[CTRL_FLUSH];
    assign w_w1c     = w_wr_b0 & (w_sel == REG_STATUS);
    assign w_sw_push = reg_we_i & (|reg_be_i) & (w_sel == REG_DATA);
    assign w_hold    = w_head.hold[CNT_W-1:0];
    assign w_unused  = ^{reg_re_i, reg_addr_i, reg_wdata_i, w_head, w_full};

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.hold = PAT_CNT_W'(reg_wdata_i[8 +: CNT_W]);
        w_push_entry.pins = 8'(reg_wdata_i[GPIO_NUM-1:0]);
    end

`ifdef GPIO_PATTERN_LOOP_EN
    logic r_loop;
    assign w_loop   = r_loop;
    assign w_repush = w_pop & r_loop;
`else
    assign w_loop   = 1'b0;
    assign w_repush = 1'b0;
`endif

    gpio_pattern_fifo #(
        .DATA_W ($bits(pat_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (w_flush),
        .push_i      (w_sw_push),
        .push_data_i (w_push_entry),
        .repush_i    (w_repush),
        .pop_i       (w_pop),
        .rdata_c     (w_head),
        .push_ok_c   (w_push_ok),
        .empty_c     (w_empty),
        .full_c      (w_full),
        .level_c     (w_level)
    );

    // Next-state: each entry is visible for max(hold,1) cycles with no gap between entries.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_pop       = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_flush && r_enable && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = HOLD;
                    w_data_nxt  = w_head.pins[GPIO_NUM-1:0];
                    w_cnt_nxt   = (w_hold == '0) ? '0 : w_hold - CNT_W'(1);
                end
            end
            HOLD: begin
                if (w_flush || !r_enable) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_data_nxt = w_head.pins[GPIO_NUM-1:0];
                    w_cnt_nxt  = (w_hold == '0) ? '0 : w_hold - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_done_set  = ~w_loop;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Register file; hardware set of done/ovf wins over a same-cycle W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_oe     <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= reg_wdata_i[CTRL_ENABLE];
                r_irq_en <= reg_wdata_i[CTRL_IRQ_EN];
            end
            if (w_wr_b0 && (w_sel == REG_OE)) begin
                r_oe <= reg_wdata_i[GPIO_NUM-1:0];
            end
            r_done <= w_done_set | (r_done & ~(w_w1c & reg_wdata_i[ST_DONE]));
            r_ovf  <= (w_sw_push & ~w_push_ok & ~w_flush) |
                      (r_ovf & ~(w_w1c & reg_wdata_i[ST_OVF]));
        end
    end

`ifdef GPIO_PATTERN_LOOP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_loop <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_loop <= reg_wdata_i[CTRL_LOOP];
        end
    end
`endif

    always_comb begin
        reg_rdata_o = '0;
        case (w_sel)
            REG_CTRL: begin
                reg_rdata_o[CTRL_ENABLE] = r_enable;
                reg_rdata_o[CTRL_LOOP]   = w_loop;
                reg_rdata_o[CTRL_IRQ_EN] = r_irq_en;
            end
            REG_STATUS: begin
                reg_rdata_o[ST_DONE]        = r_done;
                reg_rdata_o[ST_OVF]         = r_ovf;
                reg_rdata_o[ST_BUSY]        = (r_state == HOLD);
                reg_rdata_o[ST_EMPTY]       = w_empty;
                reg_rdata_o[ST_FULL]        = w_full;
                reg_rdata_o[ST_LEVEL +: 8]  = 8'(w_level);
            end
            REG_OE:  reg_rdata_o[GPIO_NUM-1:0] = r_oe;
            default: reg_rdata_o = '0;
        endcase
    end

    assign gpio_oe_o   = r_oe;
    assign gpio_data_o = r_data;
    assign irq_o       = r_done & r_irq_en;

endmodule
